// File: rtl/instr_tx.sv
// Two-byte UART (8N1) instruction transmitter: sends instr[7:0] then instr[15:8].
// Optional inter-byte idle gap enabled by defining INSTR_TX_GAP_EN.
module instr_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int GAP_BITS     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tx_dv,
    input  logic [15:0] i_tx_instr,
    output logic        o_tx_serial,
    output logic        o_tx_active,
    output logic        o_tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
`ifdef INSTR_TX_GAP_EN
        GAP     = 3'd4,
`endif
        CLEANUP = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             byte_idx_q, byte_idx_d;
    logic [15:0]      instr_q, instr_d;
    logic             serial_q, serial_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic [7:0]       cur_byte;
    logic             bit_end;

`ifdef INSTR_TX_GAP_EN
    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_BITS - 1);
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`else
    logic unused_gap_bits;
    assign unused_gap_bits = (GAP_BITS != 0);
`endif

    assign cur_byte = byte_idx_q ? instr_q[15:8] : instr_q[7:0];
    assign bit_end  = (clk_cnt_q == CNT_MAX);

    // Next-state logic; serial/active/done are computed for the next cycle so outputs are registered.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        instr_d    = instr_q;
        serial_d   = 1'b1;
        active_d   = 1'b1;
        done_d     = 1'b0;
`ifdef INSTR_TX_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_tx_dv) begin
                    instr_d    = i_tx_instr;
                    state_d    = START;
                    clk_cnt_d  = '0;
                    bit_idx_d  = 3'd0;
                    byte_idx_d = 1'b0;
                    serial_d   = 1'b0;
                    active_d   = 1'b1;
                end else begin
                    active_d   = 1'b0;
                end
            end
            START: begin
                serial_d = 1'b0;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                    serial_d  = cur_byte[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                serial_d = cur_byte[bit_idx_q];
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d  = STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = cur_byte[bit_idx_q + 3'd1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (byte_idx_q == 1'b0) begin
                        byte_idx_d = 1'b1;
`ifdef INSTR_TX_GAP_EN
                        state_d    = GAP;
                        gap_cnt_d  = '0;
`else
                        state_d    = START;
                        serial_d   = 1'b0;
`endif
                    end else begin
                        state_d  = CLEANUP;
                        done_d   = 1'b1;
                        active_d = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`ifdef INSTR_TX_GAP_EN
            GAP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (gap_cnt_q == GAP_MAX) begin
                        gap_cnt_d = '0;
                        state_d   = START;
                        serial_d  = 1'b0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`endif
            CLEANUP: begin
                state_d    = IDLE;
                active_d   = 1'b0;
                byte_idx_d = 1'b0;
                bit_idx_d  = 3'd0;
            end
            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset that aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 1'b0;
            instr_q    <= 16'h0000;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
`ifdef INSTR_TX_GAP_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            instr_q    <= instr_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            done_q     <= done_d;
`ifdef INSTR_TX_GAP_EN
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    assign o_tx_serial = serial_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;

endmodule

// File: tb/tb_instr_tx.sv
// Directed bench for instr_tx: a 217-clock instance for framing/busy/reset tests
// and a 4-clock instance for back-to-back requests.
module tb_instr_tx;

    localparam int CPB_A = 217;
    localparam int CPB_B = 4;
    localparam int GB    = 10;
`ifdef INSTR_TX_GAP_EN
    localparam int G = GB;
`else
    localparam int G = 0;
`endif
    localparam int FA = (20 + G) * CPB_A;
    localparam int FB = (20 + G) * CPB_B;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv_a, dv_b;
    logic [15:0] instr_a, instr_b;
    logic        ser_a, act_a, done_a;
    logic        ser_b, act_b, done_b;

    int n_pass  = 0;
    int n_total = 0;

    logic ln_s [0:8191];
    logic dn_s [0:8191];
    logic ac_s [0:8191];

    always #5 clk = ~clk;

    instr_tx #(.CLKS_PER_BIT(CPB_A), .GAP_BITS(GB)) dut_a (
        .clk(clk), .rst(rst), .i_tx_dv(dv_a), .i_tx_instr(instr_a),
        .o_tx_serial(ser_a), .o_tx_active(act_a), .o_tx_done(done_a)
    );

    instr_tx #(.CLKS_PER_BIT(CPB_B), .GAP_BITS(GB)) dut_b (
        .clk(clk), .rst(rst), .i_tx_dv(dv_b), .i_tx_instr(instr_b),
        .o_tx_serial(ser_b), .o_tx_active(act_b), .o_tx_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Record one instance's outputs each negedge; optionally inject a dv pulse (kind 1) or rst+dv (kind 2) on A.
    task automatic capture(input int sel, input int ncyc, input int kind, input int at, input logic [15:0] val);
        for (int c = 0; c < ncyc; c++) begin
            ln_s[c] = (sel != 0) ? ser_b : ser_a;
            dn_s[c] = (sel != 0) ? done_b : done_a;
            ac_s[c] = (sel != 0) ? act_b : act_a;
            if (kind != 0 && c == at) begin
                dv_a = 1'b1;
                if (kind == 1) instr_a = val;
                else rst = 1'b1;
            end
            if (kind != 0 && c == at + 1) begin
                dv_a = 1'b0;
                rst  = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic start_a(input logic [15:0] val);
        @(negedge clk);
        dv_a    = 1'b1;
        instr_a = val;
        @(posedge clk);
        @(negedge clk);
        dv_a    = 1'b0;
    endtask

    function automatic logic [15:0] decode(input int off, input int cpb);
        logic [15:0] d;
        for (int k = 0; k < 8; k++) begin
            d[k]     = ln_s[off + (1 + k) * cpb + cpb / 2];
            d[8 + k] = ln_s[off + (11 + G + k) * cpb + cpb / 2];
        end
        return d;
    endfunction

    function automatic logic framing_ok(input int off, input int cpb);
        return (ln_s[off + cpb / 2] == 1'b0) && (ln_s[off + 9 * cpb + cpb / 2] == 1'b1) &&
               (ln_s[off + (10 + G) * cpb + cpb / 2] == 1'b0) &&
               (ln_s[off + (19 + G) * cpb + cpb / 2] == 1'b1);
    endfunction

    function automatic int count_done(input int from, input int to);
        int n = 0;
        for (int i = from; i < to; i++) if (dn_s[i]) n++;
        return n;
    endfunction

    function automatic int count_low(input int from, input int to);
        int n = 0;
        for (int i = from; i < to; i++) if (!ln_s[i]) n++;
        return n;
    endfunction

    function automatic int count_act(input int from, input int to);
        int n = 0;
        for (int i = from; i < to; i++) if (ac_s[i]) n++;
        return n;
    endfunction

    function automatic int first_done(input int to);
        for (int i = 0; i < to; i++) if (dn_s[i]) return i;
        return -1;
    endfunction

    initial begin
        rst = 1'b1; dv_a = 1'b0; dv_b = 1'b0; instr_a = 16'h0000; instr_b = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_serial", 32'(ser_a), 32'd1);
        check("reset_active", 32'(act_a), 32'd0);
        check("reset_done",   32'(done_a), 32'd0);
        check("reset_serial_b", 32'(ser_b), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic send of 0xAB37
        start_a(16'hAB37);
        capture(0, FA + 10, 0, 0, 16'h0000);
        check("basic_first_low",  32'(ln_s[0]), 32'd0);
        check("basic_first_act",  32'(ac_s[0]), 32'd1);
        check("basic_data",       32'(decode(0, CPB_A)), 32'h0000AB37);
        check("basic_framing",    32'(framing_ok(0, CPB_A)), 32'd1);
        check("basic_done_at",    32'(first_done(FA + 10)), 32'(FA));
        check("basic_done_count", 32'(count_done(0, FA + 10)), 32'd1);
        check("basic_active_len", 32'(count_act(0, FA + 10)), 32'(FA));
        check("basic_cleanup_high", 32'(ln_s[FA]), 32'd1);
        check("basic_byte0_stop_end", 32'(ln_s[10 * CPB_A - 1]), 32'd1);
        check("basic_byte1_start", 32'(ln_s[(10 + G) * CPB_A]), 32'd0);
        check("basic_gap_lows", 32'(count_low(10 * CPB_A, (10 + G) * CPB_A)), 32'd0);

        // Busy-ignore: 0x1234 requested 100 cycles into the frame
        start_a(16'hAB37);
        capture(0, FA + 300, 1, 100, 16'h1234);
        check("busy_data",       32'(decode(0, CPB_A)), 32'h0000AB37);
        check("busy_done_count", 32'(count_done(0, FA + 300)), 32'd1);
        check("busy_no_second",  32'(count_low(FA, FA + 300)), 32'd0);

        // Reset during byte-0 data bit 3, with dv also high during reset
        start_a(16'hAB37);
        capture(0, FA + 20, 2, 4 * CPB_A + 50, 16'h0000);
        check("rst_line_high", 32'(ln_s[4 * CPB_A + 51]), 32'd1);
        check("rst_active_low", 32'(ac_s[4 * CPB_A + 51]), 32'd0);
        check("rst_no_done", 32'(count_done(0, FA + 20)), 32'd0);
        check("rst_no_resume", 32'(count_low(4 * CPB_A + 51, FA + 20)), 32'd0);

        // Normal send after the abort
        start_a(16'h00FF);
        capture(0, FA + 10, 0, 0, 16'h0000);
        check("after_rst_data",    32'(decode(0, CPB_A)), 32'h000000FF);
        check("after_rst_framing", 32'(framing_ok(0, CPB_A)), 32'd1);
        check("after_rst_done_at", 32'(first_done(FA + 10)), 32'(FA));

        // Back-to-back on the fast instance with dv held high
        @(negedge clk);
        dv_b    = 1'b1;
        instr_b = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        instr_b = 16'hFFFF;
        capture(1, 2 * FB + 12, 0, 0, 16'h0000);
        dv_b = 1'b0;
        check("b2b_pair0_data",   32'(decode(0, CPB_B)), 32'h00000000);
        check("b2b_pair1_data",   32'(decode(FB + 2, CPB_B)), 32'h0000FFFF);
        check("b2b_pair0_frame",  32'(framing_ok(0, CPB_B)), 32'd1);
        check("b2b_pair1_frame",  32'(framing_ok(FB + 2, CPB_B)), 32'd1);
        check("b2b_done0",        32'(dn_s[FB]), 32'd1);
        check("b2b_done1",        32'(dn_s[2 * FB + 2]), 32'd1);
        check("b2b_done_count",   32'(count_done(0, 2 * FB + 12)), 32'd2);
        check("b2b_gap_high",     32'(count_low(FB, FB + 2)), 32'd0);
        check("b2b_restart_low",  32'(ln_s[FB + 2]), 32'd0);
        check("b2b_last_stop",    32'(ln_s[FB - 1]), 32'd1);
        repeat (2 * FB) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
